// File: rtl/branch_fwd_unit_pkg.sv
`default_nettype none
//==============================================================================
// branch_fwd_unit_pkg -- forwarding-select encodings, LOAD opcode, entry type
// Revision 1.0
//==============================================================================
package branch_fwd_unit_pkg;

  localparam logic [1:0] FWD_RF     = 2'd0;
  localparam logic [1:0] FWD_MEM    = 2'd1;
  localparam logic [1:0] FWD_WB_ALU = 2'd2;
  localparam logic [1:0] FWD_WB_LD  = 2'd3;

  localparam logic [6:0] LOAD_OPCODE = 7'b0000011;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } fwd_entry_t;

endpackage
`default_nettype wire

// File: rtl/branch_fwd_unit_if.sv
`default_nettype none
//==============================================================================
// branch_fwd_unit_if -- ID-stage operand request and resolution bundle
// Revision 1.0
//==============================================================================
interface branch_fwd_unit_if #(
  parameter int XLEN  = 32,
  parameter int NSRC  = 2,
  parameter int CNT_W = 16
);
  logic                 id_valid;
  logic [NSRC*5-1:0]    id_rs;
  logic [NSRC-1:0]      id_rs_used;
  logic [4:0]           id_rd;
  logic                 id_we;
  logic                 id_is_load;
  logic                 flush;
  logic                 fwd_en;
  logic [NSRC*XLEN-1:0] rf_data;
  logic [XLEN-1:0]      mem_val;
  logic [XLEN-1:0]      wb_alu_val;
  logic [XLEN-1:0]      wb_load_val;
  logic [NSRC*XLEN-1:0] operand;
  logic [NSRC*2-1:0]    fwd_sel;
  logic                 stall;
  logic [CNT_W-1:0]     stall_cnt;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_we, id_is_load, flush, fwd_en,
           rf_data, mem_val, wb_alu_val, wb_load_val,
    input  operand, fwd_sel, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd, id_we, id_is_load, flush, fwd_en,
           rf_data, mem_val, wb_alu_val, wb_load_val,
    output operand, fwd_sel, stall, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/branch_fwd_unit_fwd_src_resolve.sv
`default_nettype none
//==============================================================================
// fwd_src_resolve -- picks the bypass source or a stall for one ID operand
// Revision 1.0
//==============================================================================
module fwd_src_resolve
  import branch_fwd_unit_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       rs_used,
  input  logic       id_valid,
  input  logic       fwd_en,
  input  fwd_entry_t ex,
  input  fwd_entry_t mem,
  input  fwd_entry_t wb,
  output logic [1:0] sel,
  output logic       stall_req
);

  logic w_hit_ex;
  logic w_hit_mem;
  logic w_hit_wb;
  logic w_unused_ex_ld;

  // x0 never matches, so rs==0 always falls through to the register file
  assign w_hit_ex  = ex.valid  && ex.we  && (ex.rd  != 5'd0) && (ex.rd  == rs) && rs_used && id_valid;
  assign w_hit_mem = mem.valid && mem.we && (mem.rd != 5'd0) && (mem.rd == rs) && rs_used && id_valid;
  assign w_hit_wb  = wb.valid  && wb.we  && (wb.rd  != 5'd0) && (wb.rd  == rs) && rs_used && id_valid;

  // an EX-stage producer stalls whether or not it is a load
  assign w_unused_ex_ld = ex.ld;

  always_comb begin
    sel       = FWD_RF;
    stall_req = 1'b0;
    if (w_hit_ex) begin
      stall_req = 1'b1;
    end else if (w_hit_mem) begin
      if (!fwd_en || mem.ld) stall_req = 1'b1;
      else                   sel       = FWD_MEM;
    end else if (w_hit_wb) begin
      if (!fwd_en) stall_req = 1'b1;
      else         sel       = wb.ld ? FWD_WB_LD : FWD_WB_ALU;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_fwd_unit.sv
`default_nettype none
//==============================================================================
// branch_fwd_unit -- ID-stage hazard tracking, operand bypass and stall control
// Revision 1.0
//==============================================================================
module branch_fwd_unit
  import branch_fwd_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NSRC  = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_fwd_unit_if.slave   bus
);

  fwd_entry_t        r_ex;
  fwd_entry_t        r_mem;
  fwd_entry_t        r_wb;
  fwd_entry_t        w_ex_next;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [NSRC-1:0]   w_stall_req;
  logic [NSRC*2-1:0] w_sel;
  logic              w_stall;

  generate
    for (genvar i = 0; i < NSRC; i++) begin : g_src
      logic [XLEN-1:0] w_op;

      fwd_src_resolve u_resolve (
        .rs        (bus.id_rs[5*i +: 5]),
        .rs_used   (bus.id_rs_used[i]),
        .id_valid  (bus.id_valid),
        .fwd_en    (bus.fwd_en),
        .ex        (r_ex),
        .mem       (r_mem),
        .wb        (r_wb),
        .sel       (w_sel[2*i +: 2]),
        .stall_req (w_stall_req[i])
      );

      always_comb begin
        w_op = bus.rf_data[XLEN*i +: XLEN];
        case (w_sel[2*i +: 2])
          FWD_MEM:    w_op = bus.mem_val;
          FWD_WB_ALU: w_op = bus.wb_alu_val;
          FWD_WB_LD:  w_op = bus.wb_load_val;
          default:    w_op = bus.rf_data[XLEN*i +: XLEN];
        endcase
      end

      assign bus.operand[XLEN*i +: XLEN] = w_op;
    end
  endgenerate

  // flush kills the ID instruction, so it can never be the one that stalls
  assign w_stall = (|w_stall_req) && bus.id_valid && !bus.flush;

  always_comb begin
    w_ex_next = '0;
    if (bus.id_valid && !w_stall && !bus.flush) begin
      w_ex_next.valid = 1'b1;
      w_ex_next.rd    = bus.id_rd;
      w_ex_next.we    = bus.id_we;
      w_ex_next.ld    = bus.id_is_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_ex  <= w_ex_next;
      r_mem <= r_ex;
      r_wb  <= r_mem;
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.stall     = w_stall;
  assign bus.fwd_sel   = w_sel;
  assign bus.stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_fwd_unit.sv
`default_nettype none
//==============================================================================
// tb_branch_fwd_unit -- directed scenarios plus random stream vs. history model
// Revision 1.0
//==============================================================================
module tb_branch_fwd_unit;
  import branch_fwd_unit_pkg::*;

  localparam int XLEN    = 32;
  localparam int NSRC    = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_fwd_unit_if #(.XLEN(XLEN), .NSRC(NSRC), .CNT_W(CNT_W)) bus ();

  branch_fwd_unit #(.XLEN(XLEN), .NSRC(NSRC), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_vec = 0;
  int         n_err = 0;
  fwd_entry_t hist [3];   // index = age in cycles since issue: 0=EX, 1=MEM, 2=WB
  int         cnt_m = 0;
  logic       last_es = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_eval(output logic es, output logic [2*NSRC-1:0] esel,
                            output logic [NSRC*XLEN-1:0] eop);
    logic any;
    any  = 1'b0;
    esel = '0;
    eop  = '0;
    for (int s = 0; s < NSRC; s++) begin
      logic [4:0]      rs;
      logic [1:0]      sel;
      logic [XLEN-1:0] v;
      int              age;
      rs  = bus.id_rs[5*s +: 5];
      age = -1;
      for (int a = 0; a < 3; a++)
        if (age < 0 && hist[a].valid && hist[a].we && hist[a].rd != 5'd0 &&
            hist[a].rd == rs && bus.id_rs_used[s] && bus.id_valid)
          age = a;
      sel = FWD_RF;
      if (age == 0) any = 1'b1;
      else if (age == 1) begin
        if (!bus.fwd_en || hist[1].ld) any = 1'b1; else sel = FWD_MEM;
      end else if (age == 2) begin
        if (!bus.fwd_en) any = 1'b1; else sel = hist[2].ld ? FWD_WB_LD : FWD_WB_ALU;
      end
      case (sel)
        FWD_MEM:    v = bus.mem_val;
        FWD_WB_ALU: v = bus.wb_alu_val;
        FWD_WB_LD:  v = bus.wb_load_val;
        default:    v = bus.rf_data[XLEN*s +: XLEN];
      endcase
      esel[2*s +: 2]     = sel;
      eop[XLEN*s +: XLEN] = v;
    end
    es = any && bus.id_valid && !bus.flush;
  endtask

  task automatic check_now(input string tag);
    logic                 es;
    logic [2*NSRC-1:0]    esel;
    logic [NSRC*XLEN-1:0] eop;
    #1;
    model_eval(es, esel, eop);
    last_es = es;
    check({tag, ".stall"}, 64'(bus.stall), 64'(es));
    check({tag, ".cnt"}, 64'(bus.stall_cnt), 64'(cnt_m));
    if (!es || !bus.fwd_en) check({tag, ".sel"}, 64'(bus.fwd_sel), 64'(esel));
    if (!es) check({tag, ".op"}, 64'(bus.operand), 64'(eop));
  endtask

  task automatic tick();
    @(posedge clk);
    if (last_es && cnt_m < CNT_MAX) cnt_m++;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = '0;
    if (bus.id_valid && !last_es && !bus.flush) begin
      hist[0].valid = 1'b1;
      hist[0].rd    = bus.id_rd;
      hist[0].we    = bus.id_we;
      hist[0].ld    = bus.id_is_load;
    end
    @(negedge clk);
  endtask

  task automatic step(input string tag);
    check_now(tag);
    tick();
  endtask

  task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] used, input logic [4:0] rd, input logic we,
                       input logic [6:0] opc, input logic fl, input logic fe);
    bus.id_valid   = v;
    bus.id_rs      = {rs1, rs0};
    bus.id_rs_used = used;
    bus.id_rd      = rd;
    bus.id_we      = we;
    bus.id_is_load = (opc == LOAD_OPCODE);
    bus.flush      = fl;
    bus.fwd_en     = fe;
  endtask

  task automatic set_vals(input logic [63:0] rf, input logic [31:0] mv,
                          input logic [31:0] wa, input logic [31:0] wl);
    bus.rf_data     = rf;
    bus.mem_val     = mv;
    bus.wb_alu_val  = wa;
    bus.wb_load_val = wl;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, OP_ALU, 1'b0, 1'b1);
    for (int k = 0; k < n; k++) step("idle");
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, ".stall"}, 64'(bus.stall), 64'd0);
    check({tag, ".cnt"}, 64'(bus.stall_cnt), 64'd0);
    check({tag, ".sel"}, 64'(bus.fwd_sel), 64'd0);
    check({tag, ".op"}, 64'(bus.operand), 64'(bus.rf_data));
    for (int a = 0; a < 3; a++) hist[a] = '0;
    cnt_m   = 0;
    last_es = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_vals(64'h1111_2222_3333_4444, 32'h0000_00AA, 32'h0000_0055, 32'hDEAD_BEEF);
    drive(1'b1, 5'd5, 5'd5, 2'b11, 5'd0, 1'b0, OP_BR, 1'b0, 1'b1);
    @(negedge clk);
    apply_reset("reset");

    // ALU producer of x5, consumer next cycle
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, OP_ALU, 1'b0, 1'b1); step("r41.wr");
    drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, OP_BR, 1'b0, 1'b1);
    check_now("r41.c0"); check("r41.stall", 64'(bus.stall), 64'd1); tick();
    check_now("r41.c1"); check("r41.sel", 64'(bus.fwd_sel[1:0]), 64'd1);
    check("r41.op", 64'(bus.operand[31:0]), 64'h0000_00AA); tick();
    idle(3);

    // load to x7, consumer next cycle
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, LOAD_OPCODE, 1'b0, 1'b1); step("r42.ld");
    drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, OP_BR, 1'b0, 1'b1);
    check_now("r42.c0"); check("r42.stall0", 64'(bus.stall), 64'd1); tick();
    check_now("r42.c1"); check("r42.stall1", 64'(bus.stall), 64'd1); tick();
    check_now("r42.c2"); check("r42.sel", 64'(bus.fwd_sel[1:0]), 64'd3);
    check("r42.op", 64'(bus.operand[31:0]), 64'hDEAD_BEEF); tick();
    idle(3);

    // x0 is never forwarded
    set_vals(64'h1234_5678_0000_0000, 32'h0000_00AA, 32'h0000_0055, 32'hDEAD_BEEF);
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, OP_ALU, 1'b0, 1'b1); step("r43.wr");
    drive(1'b1, 5'd0, 5'd0, 2'b01, 5'd0, 1'b0, OP_BR, 1'b0, 1'b1);
    check_now("r43.br"); check("r43.stall", 64'(bus.stall), 64'd0);
    check("r43.op", 64'(bus.operand[31:0]), 64'd0); tick();
    idle(3);

    // two back-to-back writers of x3: the younger (MEM) wins, both sources agree
    set_vals(64'h1111_2222_3333_4444, 32'h0000_00AA, 32'h0000_0055, 32'hDEAD_BEEF);
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, OP_ALU, 1'b0, 1'b1); step("r44.w0");
    step("r44.w1");
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b0, OP_ALU, 1'b0, 1'b1); step("r44.nop");
    idle(3);
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, OP_ALU, 1'b0, 1'b1); step("r44.w2");
    step("r44.w3");
    drive(1'b1, 5'd3, 5'd3, 2'b11, 5'd0, 1'b0, OP_BR, 1'b0, 1'b1);
    check_now("r44.br0"); check("r44.stall", 64'(bus.stall), 64'd1); tick();
    check_now("r44.br1"); check("r44.sel", 64'(bus.fwd_sel), 64'h5);
    check("r44.op1", 64'(bus.operand[63:32]), 64'h0000_00AA); tick();
    idle(3);

    // interlock-only mode, producer two cycles ahead
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, OP_ALU, 1'b0, 1'b0); step("r45.wr");
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, OP_ALU, 1'b0, 1'b0); step("r45.mid");
    drive(1'b1, 5'd4, 5'd0, 2'b01, 5'd0, 1'b0, OP_BR, 1'b0, 1'b0);
    check_now("r45.c0"); check("r45.stall0", 64'(bus.stall), 64'd1); tick();
    check_now("r45.c1"); check("r45.stall1", 64'(bus.stall), 64'd1); tick();
    check_now("r45.c2"); check("r45.stall2", 64'(bus.stall), 64'd0);
    check("r45.sel", 64'(bus.fwd_sel), 64'd0);
    check("r45.op", 64'(bus.operand[31:0]), 64'h3333_4444); tick();
    idle(3);

    // a self-dependent stream in interlock mode stalls 3 of every 4 cycles
    apply_reset("r46.pre");
    drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd1, 1'b1, OP_ALU, 1'b0, 1'b0);
    for (int k = 0; k < 32; k++) step("r46.run");
    check("r46.sat", 64'(bus.stall_cnt), 64'(CNT_MAX));
    for (int k = 0; k < 4; k++) begin
      check_now("r46.seek");
      if (last_es) break;
      tick();
    end
    check("r46.stalling", 64'(bus.stall), 64'd1);
    apply_reset("r46.rst");
    step("r46.after");

    // random stream
    for (int k = 0; k < 400; k++) begin
      logic [6:0] opc;
      if ($urandom_range(0, 99) == 0) apply_reset("rnd.rst");
      opc = ($urandom_range(0, 9) < 3) ? LOAD_OPCODE : OP_ALU;
      set_vals({$urandom, $urandom}, $urandom, $urandom, $urandom);
      drive($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            2'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), opc,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
